// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad charge-entry slice: state encoding, key codes,
// BCD width, default limits and the digit acceptance rule.
package keypad_pkg;

   localparam int BCD_W           = 4;
   localparam int DEF_MAX_AMOUNT  = 20;
   localparam int DEF_TIMEOUT_CYC = 30510;

   localparam logic [BCD_W-1:0] KEY_NONE = 4'b1111;

   typedef logic [2:0] state_t;

   localparam state_t ST_OFF       = 3'b001;
   localparam state_t ST_ENTRY     = 3'b010;
   localparam state_t ST_CONFIRMED = 3'b100;

   // True when digit d may be appended to the current entry without exceeding max_amt.
   function automatic logic digit_fits(input logic [BCD_W-1:0] ones,
                                       input logic [BCD_W-1:0] d,
                                       input logic [1:0]       cnt,
                                       input logic [7:0]       max_amt);
      logic [7:0] val;
      val = (cnt == 2'd0) ? {4'b0000, d} : ({4'b0000, ones} * 8'd10 + {4'b0000, d});
      return (cnt != 2'd2) && (val <= max_amt);
   endfunction

endpackage

// File: rtl/key_entry_ctrl_evt_detect.sv
// Key-press edge detector: one-cycle evt_o on the falling edge of key_idle_i,
// seen one CLK edge after the first low sample; no backpressure.
module key_evt_detect (
   input  logic CLK,
   input  logic anti_shake_cnt_reset,
   input  logic key_idle_i,
   output logic evt_o
);

   logic idle_d1_q;
   logic idle_d2_q;

   always_ff @(posedge CLK or posedge anti_shake_cnt_reset) begin
      if (anti_shake_cnt_reset) begin
         idle_d1_q <= 1'b1;
         idle_d2_q <= 1'b1;
      end else begin
         idle_d1_q <= key_idle_i;
         idle_d2_q <= idle_d1_q;
      end
   end

   assign evt_o = !idle_d1_q && idle_d2_q;

endmodule

// File: rtl/key_entry_ctrl.sv
// Charge-amount entry FSM: key events commit two CLK edges after key_idle falls,
// confirm/key_err are registered one-cycle pulses; no backpressure, amount held until charge_done.
module key_entry_ctrl
   import keypad_pkg::*;
#(
   parameter int MAX_AMOUNT  = DEF_MAX_AMOUNT,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic             CLK,
   input  logic             anti_shake_cnt_reset,
   input  logic [BCD_W-1:0] key_data,
   input  logic             key_start,
   input  logic             key_reset,
   input  logic             key_ok,
   input  logic             key_idle,
   input  logic             charge_done,
   output logic [BCD_W-1:0] amount_tens,
   output logic [BCD_W-1:0] amount_ones,
   output logic [1:0]       digit_cnt,
   output logic             entry_active,
   output logic             busy,
   output logic             confirm,
   output logic             key_err
);

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
   localparam logic [7:0]  MAX_VAL  = 8'(MAX_AMOUNT);

   state_t           state_q, state_d;
   logic [BCD_W-1:0] tens_q, tens_d, ones_q, ones_d;
   logic [1:0]       dcnt_q, dcnt_d;
   logic [15:0]      tmo_q, tmo_d;
   logic             confirm_q, confirm_d, err_q, err_d;
   logic             evt, is_digit, amount_zero;

   key_evt_detect u_evt (
      .CLK                  (CLK),
      .anti_shake_cnt_reset (anti_shake_cnt_reset),
      .key_idle_i           (key_idle),
      .evt_o                (evt)
   );

   assign is_digit    = (key_data != KEY_NONE) && (key_data <= 4'd9);
   assign amount_zero = (tens_q == '0) && (ones_q == '0);

   always_ff @(posedge CLK or posedge anti_shake_cnt_reset) begin
      if (anti_shake_cnt_reset) begin
         state_q   <= ST_OFF;
         tens_q    <= '0;
         ones_q    <= '0;
         dcnt_q    <= '0;
         tmo_q     <= '0;
         confirm_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         tens_q    <= tens_d;
         ones_q    <= ones_d;
         dcnt_q    <= dcnt_d;
         tmo_q     <= tmo_d;
         confirm_q <= confirm_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      tens_d    = tens_q;
      ones_d    = ones_q;
      dcnt_d    = dcnt_q;
      tmo_d     = '0;
      confirm_d = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         ST_OFF: begin
            if (evt && key_start) begin
               state_d = ST_ENTRY;
               tens_d  = '0;
               ones_d  = '0;
               dcnt_d  = '0;
            end
         end
         ST_ENTRY: begin
            tmo_d = tmo_q + 16'd1;
            // A key event on the expiry cycle takes precedence over the timeout.
            if (evt) begin
               tmo_d = '0;
               if (key_start || key_reset) begin
                  tens_d = '0;
                  ones_d = '0;
                  dcnt_d = '0;
               end else if (key_ok) begin
                  if (amount_zero) begin
                     err_d = 1'b1;
                  end else begin
                     state_d   = ST_CONFIRMED;
                     confirm_d = 1'b1;
                  end
               end else if (is_digit) begin
                  if (digit_fits(ones_q, key_data, dcnt_q, MAX_VAL)) begin
                     tens_d = ones_q;
                     ones_d = key_data;
                     dcnt_d = dcnt_q + 2'd1;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end else if (tmo_q == TMO_LAST) begin
               state_d = ST_OFF;
               tens_d  = '0;
               ones_d  = '0;
               dcnt_d  = '0;
               tmo_d   = '0;
               err_d   = 1'b1;
            end
         end
         ST_CONFIRMED: begin
            if (charge_done || (evt && key_reset)) begin
               state_d = ST_OFF;
               tens_d  = '0;
               ones_d  = '0;
               dcnt_d  = '0;
            end
         end
         default: begin
            state_d = ST_OFF;
            tens_d  = '0;
            ones_d  = '0;
            dcnt_d  = '0;
         end
      endcase
   end

   always_comb begin
      entry_active = (state_q == ST_ENTRY);
      busy         = (state_q == ST_CONFIRMED);
   end

   assign amount_tens = tens_q;
   assign amount_ones = ones_q;
   assign digit_cnt   = dcnt_q;
   assign confirm     = confirm_q;
   assign key_err     = err_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed bench for key_entry_ctrl: session entry, digit limits, confirm/charge handshake,
// inactivity timeout boundary and asynchronous reset with a held key.
module tb_key_entry_ctrl;

   localparam int HOLD = 20;
   localparam int TMO  = 100;

   logic       CLK = 1'b0;
   logic       anti_shake_cnt_reset;
   logic [3:0] key_data;
   logic       key_start, key_reset, key_ok, key_idle, charge_done;
   logic [3:0] amount_tens, amount_ones;
   logic [1:0] digit_cnt;
   logic       entry_active, busy, confirm, key_err;

   int n_cmp = 0;
   int n_bad = 0;
   int n_conf, n_err, pos_conf, pos_err;

   // {tens, ones, digit_cnt, entry_active, busy}
   logic [11:0] status;
   assign status = {amount_tens, amount_ones, digit_cnt, entry_active, busy};

   always #5 CLK = ~CLK;

   key_entry_ctrl #(.MAX_AMOUNT(20), .TIMEOUT_CYC(TMO)) dut (
      .CLK                  (CLK),
      .anti_shake_cnt_reset (anti_shake_cnt_reset),
      .key_data             (key_data),
      .key_start            (key_start),
      .key_reset            (key_reset),
      .key_ok               (key_ok),
      .key_idle             (key_idle),
      .charge_done          (charge_done),
      .amount_tens          (amount_tens),
      .amount_ones          (amount_ones),
      .digit_cnt            (digit_cnt),
      .entry_active         (entry_active),
      .busy                 (busy),
      .confirm              (confirm),
      .key_err              (key_err)
   );

   task automatic idle_inputs();
      key_data  = 4'hF;
      key_start = 1'b0;
      key_reset = 1'b0;
      key_ok    = 1'b0;
      key_idle  = 1'b1;
   endtask

   // Full press/release; counts confirm and key_err pulses, pos_* is the sample index of the first one.
   task automatic press(input logic [3:0] d, input logic s, input logic r, input logic o);
      n_conf = 0; n_err = 0; pos_conf = 0; pos_err = 0;
      @(posedge CLK); #1;
      key_data = d; key_start = s; key_reset = r; key_ok = o; key_idle = 1'b0;
      for (int i = 1; i <= 2 * HOLD + 1; i++) begin
         if (i == HOLD + 1) begin
            @(posedge CLK); #1;
            idle_inputs();
         end
         @(negedge CLK);
         if (confirm === 1'b1) begin n_conf++; if (pos_conf == 0) pos_conf = i; end
         if (key_err === 1'b1) begin n_err++;  if (pos_err == 0)  pos_err  = i; end
      end
   endtask

   // Short event; caller is just after a posedge, returns 1 time unit after the commit edge.
   task automatic key_evt(input logic [3:0] d, input logic s, input logic r, input logic o);
      #1;
      key_data = d; key_start = s; key_reset = r; key_ok = o; key_idle = 1'b0;
      @(posedge CLK);
      @(posedge CLK); #1;
      idle_inputs();
   endtask

   task automatic test_reset();
      n_cmp++;
      if (status !== 12'h000) begin n_bad++; $display("FAIL reset_status: got %h want 000", status); end
      n_cmp++;
      if ({confirm, key_err} !== 2'b00) begin n_bad++; $display("FAIL reset_pulses: got %b want 00", {confirm, key_err}); end
   endtask

   task automatic test_entry_confirm();
      press(4'hF, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (status !== {4'd0, 4'd0, 2'd0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL start_entry: got %h want 002", status); end
      press(4'd1, 1'b0, 1'b0, 1'b0);
      press(4'd5, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (status !== {4'd1, 4'd5, 2'd2, 1'b1, 1'b0}) begin n_bad++; $display("FAIL amount_15: got %h want 15a", status); end
      press(4'hF, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if ({n_conf, pos_conf, n_err} !== {32'd1, 32'd3, 32'd0}) begin
         n_bad++; $display("FAIL ok_confirm: got cnt=%0d pos=%0d err=%0d want 1/3/0", n_conf, pos_conf, n_err);
      end
      n_cmp++;
      if (status !== {4'd1, 4'd5, 2'd2, 1'b0, 1'b1}) begin n_bad++; $display("FAIL busy_state: got %h want 159", status); end
      press(4'd7, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({n_err, 20'h0, status} !== {32'd0, 20'h0, 4'd1, 4'd5, 2'd2, 1'b0, 1'b1}) begin
         n_bad++; $display("FAIL confirmed_frozen: got err=%0d st=%h want 0/159", n_err, status);
      end
      @(posedge CLK); #1 charge_done = 1'b1;
      @(posedge CLK); #1 charge_done = 1'b0;
      n_cmp++;
      if (status !== 12'h000) begin n_bad++; $display("FAIL charge_done_off: got %h want 000", status); end
   endtask

   task automatic test_max_reject();
      press(4'hF, 1'b1, 1'b0, 1'b0);
      press(4'd2, 1'b0, 1'b0, 1'b0);
      press(4'd5, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({n_err, pos_err} !== {32'd1, 32'd3}) begin n_bad++; $display("FAIL reject_25: got err=%0d pos=%0d want 1/3", n_err, pos_err); end
      n_cmp++;
      if (status !== {4'd0, 4'd2, 2'd1, 1'b1, 1'b0}) begin n_bad++; $display("FAIL reject_25_amt: got %h want 026", status); end
      press(4'd0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({n_err, 20'h0, status} !== {32'd0, 20'h0, 4'd2, 4'd0, 2'd2, 1'b1, 1'b0}) begin
         n_bad++; $display("FAIL accept_20: got err=%0d st=%h want 0/20a", n_err, status);
      end
      press(4'hA, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({n_err, 20'h0, status} !== {32'd0, 20'h0, 4'd2, 4'd0, 2'd2, 1'b1, 1'b0}) begin
         n_bad++; $display("FAIL nondigit_ignored: got err=%0d st=%h want 0/20a", n_err, status);
      end
   endtask

   task automatic test_third_digit();
      press(4'hF, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (status !== {4'd0, 4'd0, 2'd0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL reset_key_clear1: got %h want 002", status); end
      press(4'd1, 1'b0, 1'b0, 1'b0);
      press(4'd2, 1'b0, 1'b0, 1'b0);
      press(4'd3, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({n_err, 20'h0, status} !== {32'd1, 20'h0, 4'd1, 4'd2, 2'd2, 1'b1, 1'b0}) begin
         n_bad++; $display("FAIL third_digit: got err=%0d st=%h want 1/12a", n_err, status);
      end
      press(4'hF, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if ({n_err, 20'h0, status} !== {32'd0, 20'h0, 4'd0, 4'd0, 2'd0, 1'b1, 1'b0}) begin
         n_bad++; $display("FAIL reset_key_clear2: got err=%0d st=%h want 0/002", n_err, status);
      end
      press(4'hF, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if ({n_err, n_conf, 20'h0, status} !== {32'd1, 32'd0, 20'h0, 4'd0, 4'd0, 2'd0, 1'b1, 1'b0}) begin
         n_bad++; $display("FAIL ok_zero: got err=%0d conf=%0d st=%h want 1/0/002", n_err, n_conf, status);
      end
   endtask

   task automatic test_done_and_reset();
      press(4'd9, 1'b0, 1'b0, 1'b0);
      press(4'hF, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (status !== {4'd0, 4'd9, 2'd1, 1'b0, 1'b1}) begin n_bad++; $display("FAIL busy_09: got %h want 095", status); end
      @(posedge CLK); #1;
      key_reset = 1'b1; key_idle = 1'b0;
      @(posedge CLK); #1 charge_done = 1'b1;
      @(posedge CLK); #1 charge_done = 1'b0;
      n_err = 0; n_conf = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (key_err === 1'b1) n_err++;
         if (confirm === 1'b1) n_conf++;
      end
      idle_inputs();
      n_cmp++;
      if ({n_err, n_conf, 20'h0, status} !== {32'd0, 32'd0, 20'h0, 12'h000}) begin
         n_bad++; $display("FAIL done_and_reset: got err=%0d conf=%0d st=%h want 0/0/000", n_err, n_conf, status);
      end
   endtask

   task automatic test_timeout();
      @(posedge CLK); key_evt(4'hF, 1'b1, 1'b0, 1'b0);
      @(posedge CLK); key_evt(4'd1, 1'b0, 1'b0, 1'b0);
      repeat (TMO - 2) @(posedge CLK);
      #1;
      n_cmp++;
      if (status !== {4'd0, 4'd1, 2'd1, 1'b1, 1'b0}) begin n_bad++; $display("FAIL tmo_before: got %h want 016", status); end
      @(posedge CLK); #1;
      n_cmp++;
      if ({key_err, status} !== {1'b0, 4'd0, 4'd1, 2'd1, 1'b1, 1'b0}) begin
         n_bad++; $display("FAIL tmo_last_cycle: got %h want 0016", {key_err, status});
      end
      @(posedge CLK); #1;
      n_cmp++;
      if ({key_err, status} !== {1'b1, 12'h000}) begin n_bad++; $display("FAIL tmo_fire: got %h want 1000", {key_err, status}); end
      @(posedge CLK); #1;
      n_cmp++;
      if (key_err !== 1'b0) begin n_bad++; $display("FAIL tmo_pulse_width: got %b want 0", key_err); end
      @(posedge CLK); key_evt(4'hF, 1'b1, 1'b0, 1'b0);
      repeat (TMO - 2) @(posedge CLK);
      key_evt(4'd4, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({key_err, status} !== {1'b0, 4'd0, 4'd4, 2'd1, 1'b1, 1'b0}) begin
         n_bad++; $display("FAIL tmo_evt_wins: got %h want 0046", {key_err, status});
      end
      @(posedge CLK); #1;
      n_cmp++;
      if ({key_err, entry_active} !== 2'b01) begin n_bad++; $display("FAIL tmo_evt_stay: got %b want 01", {key_err, entry_active}); end
   endtask

   task automatic test_async_reset();
      @(posedge CLK); key_evt(4'd3, 1'b0, 1'b0, 1'b0);
      @(posedge CLK); #1;
      key_data = 4'd6; key_idle = 1'b0;
      #2 anti_shake_cnt_reset = 1'b1;
      #1;
      n_cmp++;
      if ({confirm, key_err, status} !== 14'h0000) begin
         n_bad++; $display("FAIL async_reset: got %h want 0000", {confirm, key_err, status});
      end
      repeat (3) @(posedge CLK);
      #1 anti_shake_cnt_reset = 1'b0;
      n_err = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         if (key_err === 1'b1) n_err++;
      end
      idle_inputs();
      n_cmp++;
      if ({n_err, 20'h0, status} !== {32'd0, 20'h0, 12'h000}) begin
         n_bad++; $display("FAIL held_after_reset: got err=%0d st=%h want 0/000", n_err, status);
      end
      press(4'd7, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({n_err, 20'h0, status} !== {32'd0, 20'h0, 12'h000}) begin
         n_bad++; $display("FAIL digit_in_off: got err=%0d st=%h want 0/000", n_err, status);
      end
      press(4'hF, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if ({n_err, n_conf} !== {32'd0, 32'd0}) begin n_bad++; $display("FAIL ok_in_off: got err=%0d conf=%0d want 0/0", n_err, n_conf); end
   endtask

   initial begin
      idle_inputs();
      charge_done = 1'b0;
      anti_shake_cnt_reset = 1'b1;
      #1;
      test_reset();
      repeat (3) @(posedge CLK);
      #1 anti_shake_cnt_reset = 1'b0;
      test_entry_confirm();
      test_max_reject();
      test_third_digit();
      test_done_and_reset();
      test_timeout();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
